// File: rtl/reg_file.sv
// Multi-port register file: one synchronous write port, two combinational read ports,
// optional write-to-read bypass, optional hard-wired zero entry, async active-high clear.
module reg_file #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok;
  logic             hit_a;
  logic             hit_b;

  // An address is "live" when it names a real, writable entry; dead addresses
  // (beyond DEPTH, or the hard-wired zero entry) drop writes and read as zero.
  function automatic logic addr_live(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_W) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign wr_ok = wr_en && addr_live(wr_addr);
  assign hit_a = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a);
  assign hit_b = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b);

  // NOTE: every entry sits on the async reset, so storage is flops rather than an
  // inferred RAM; a RAM macro could not clear all entries without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: state is updated with <= so all flops sample pre-edge values.
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the outputs and no latch is inferred.
    rd_data_a = '0;
    rd_data_b = '0;
    if (!reset) begin
      if (addr_live(rd_addr_a)) begin
        rd_data_a = hit_a ? wr_data : mem_q[rd_addr_a];
      end
      if (addr_live(rd_addr_b)) begin
        rd_data_b = hit_b ? wr_data : mem_q[rd_addr_b];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: two builds (default, and DEPTH=6/no bypass/no zero reg)
// share one stimulus stream; directed vectors, async-reset sequences and random traffic.
module tb_reg_file;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  da_def, db_def, da_alt, db_alt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(1)) u_def (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da_def), .rd_addr_b(rd_addr_b), .rd_data_b(db_def)
  );

  reg_file #(.WIDTH(16), .DEPTH(6), .BYPASS(0), .ZERO_REG(0)) u_alt (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da_alt), .rd_addr_b(rd_addr_b), .rd_data_b(db_alt)
  );

  // Reference model: index 0 = default build, index 1 = alternate build.
  int         depth_of [2] = '{8, 6};
  bit         byp_of   [2] = '{1'b1, 1'b0};
  bit         zr_of    [2] = '{1'b1, 1'b0};
  logic [W-1:0] mdl [2][8];

  function automatic logic [W-1:0] exp_rd(int k, logic [AW-1:0] a);
    if (reset) return '0;
    if (int'(a) >= depth_of[k]) return '0;
    if (zr_of[k] && a == '0) return '0;
    if (byp_of[k] && wr_en && wr_addr == a) return wr_data;
    return mdl[k][a];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) mdl[k][i] = '0;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_def_a"}, da_def, exp_rd(0, rd_addr_a));
    check({tag, "_def_b"}, db_def, exp_rd(0, rd_addr_b));
    check({tag, "_alt_a"}, da_alt, exp_rd(1, rd_addr_a));
    check({tag, "_alt_b"}, db_alt, exp_rd(1, rd_addr_b));
  endtask

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    reset     = r;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    if (r) model_clear();
  endtask

  // Commit the pending write to the model, then advance past the next rising edge.
  task automatic step();
    if (!reset && wr_en) begin
      for (int k = 0; k < 2; k++) begin
        if (int'(wr_addr) < depth_of[k] && !(zr_of[k] && wr_addr == '0))
          mdl[k][wr_addr] = wr_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  ea_d;
    logic [W-1:0]  eb_d;
    logic [W-1:0]  ea_a;
    logic [W-1:0]  eb_a;
  } vec_t;

  vec_t vt [19];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst   we    wa    wd        ra    rb    def_a     def_b     alt_a     alt_b
    vt[0]  = '{1'b1, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[1]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[2]  = '{1'b0, 1'b1, 3'd3, 16'hAAAA, 3'd3, 3'd5, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
    vt[3]  = '{1'b0, 1'b1, 3'd5, 16'hBBBB, 3'd3, 3'd5, 16'hAAAA, 16'hBBBB, 16'hAAAA, 16'h0000};
    vt[4]  = '{1'b0, 1'b0, 3'd3, 16'hCCCC, 3'd3, 3'd5, 16'hAAAA, 16'hBBBB, 16'hAAAA, 16'hBBBB};
    vt[5]  = '{1'b0, 1'b0, 3'd3, 16'hCCCC, 3'd3, 3'd5, 16'hAAAA, 16'hBBBB, 16'hAAAA, 16'hBBBB};
    vt[6]  = '{1'b0, 1'b0, 3'd3, 16'hCCCC, 3'd3, 3'd5, 16'hAAAA, 16'hBBBB, 16'hAAAA, 16'hBBBB};
    vt[7]  = '{1'b0, 1'b1, 3'd2, 16'hDDDD, 3'd2, 3'd3, 16'hDDDD, 16'hAAAA, 16'h0000, 16'hAAAA};
    vt[8]  = '{1'b0, 1'b0, 3'd2, 16'h0000, 3'd2, 3'd2, 16'hDDDD, 16'hDDDD, 16'hDDDD, 16'hDDDD};
    vt[9]  = '{1'b0, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[10] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
    vt[11] = '{1'b0, 1'b1, 3'd7, 16'h5555, 3'd7, 3'd6, 16'h5555, 16'h0000, 16'h0000, 16'h0000};
    vt[12] = '{1'b0, 1'b0, 3'd7, 16'h0000, 3'd7, 3'd5, 16'h5555, 16'hBBBB, 16'h0000, 16'hBBBB};
    vt[13] = '{1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd4, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vt[14] = '{1'b0, 1'b0, 3'd4, 16'h0000, 3'd4, 3'd3, 16'hBEEF, 16'hAAAA, 16'hBEEF, 16'hAAAA};
    vt[15] = '{1'b1, 1'b1, 3'd6, 16'h1111, 3'd6, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[16] = '{1'b0, 1'b0, 3'd6, 16'h0000, 3'd6, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[17] = '{1'b0, 1'b1, 3'd4, 16'h2222, 3'd4, 3'd4, 16'h2222, 16'h2222, 16'h0000, 16'h0000};
    vt[18] = '{1'b0, 1'b0, 3'd4, 16'h0000, 3'd4, 3'd1, 16'h2222, 16'h0000, 16'h2222, 16'h0000};

    model_clear();
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Reads while reset is held: zero everywhere.
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(7 - i);
      #1;
      check_model("rst_hold");
    end
    @(posedge clk);
    #1;

    // Just after release: every address on both ports still zero.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(7 - i);
      #1;
      check_model("post_rst");
    end
    step();

    // Directed vectors: expected values are read before the edge of each cycle.
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra, vt[i].rb);
      #1;
      check($sformatf("vec%0d_def_a", i), da_def, vt[i].ea_d);
      check($sformatf("vec%0d_def_b", i), db_def, vt[i].eb_d);
      check($sformatf("vec%0d_alt_a", i), da_alt, vt[i].ea_a);
      check($sformatf("vec%0d_alt_b", i), db_alt, vt[i].eb_a);
      step();
    end

    // Fill entries, then pulse reset between edges: the clear must not wait for clk.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, AW'(i), 16'h1000 + W'(i) * 16'h0111, AW'(i), AW'(7 - i));
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 3'd3, 3'd5);
    #1;
    check_model("prefill");
    drive(1'b1, 1'b0, '0, '0, 3'd3, 3'd5);
    #1;
    check_model("async_rst");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(7 - i);
      #1;
      check_model("async_clr");
    end
    step();

    // Random traffic against the model, with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
            AW'($urandom_range(0, 7)), W'($urandom), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)));
      #1;
      check_model("rnd");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (2..256, not necessarily a power of two).
REQ-003 The block SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 The block SHALL have derived parameter AW = ceil(log2(DEPTH)), address width; it is not user-set.
REQ-006 clk  input  1  single clock, rising edge active.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  write enable, sampled on rising clk.
REQ-009 wr_addr  input  AW  write address.
REQ-010 wr_data  input  WIDTH  write data.
REQ-011 rd_addr_a  input  AW  read port A address.
REQ-012 rd_data_a  output  WIDTH  read port A data.
REQ-013 rd_addr_b  input  AW  read port B address.
REQ-014 rd_data_b  output  WIDTH  read port B data.

Function
REQ-015 Storage SHALL be DEPTH entries of WIDTH bits; entry[wr_addr] <= wr_data on rising clk when wr_en=1 and reset=0.
REQ-016 When wr_en=0, all entries SHALL hold their value; there is no other write path.
REQ-017 Read ports SHALL be combinational: rd_data_x reflects entry[rd_addr_x] within the same cycle, zero read latency.
REQ-018 Write latency SHALL be one cycle: the value written at edge N is visible on a read of that address from after edge N.
REQ-019 With BYPASS=1, when wr_en=1 and rd_addr_x==wr_addr (valid, writable address), rd_data_x SHALL equal wr_data in that same cycle.
REQ-020 With BYPASS=0, under the same condition, rd_data_x SHALL show the old stored value until the edge.
REQ-021 Both read ports SHALL operate independently; equal addresses on A and B SHALL return identical data.
REQ-022 With ZERO_REG=1, a write to address 0 SHALL be discarded; reads of address 0 SHALL return 0, with no bypass.
REQ-023 Addresses >= DEPTH (non-power-of-two DEPTH): writes SHALL be discarded, reads SHALL return 0, no bypass.
REQ-024 Only one write per cycle; no read-modify-write, no partial/byte writes.
REQ-025 Outputs SHALL never be X after reset for any in-range or out-of-range address.

Reset
REQ-026 Assertion of reset SHALL immediately, without waiting for clk, clear every entry to 0.
REQ-027 While reset=1, writes SHALL be ignored, rd_data_a and rd_data_b SHALL read 0 for every address, and bypass SHALL be suppressed.
REQ-028 A write whose edge coincides with reset=1 SHALL be lost; reset wins.
REQ-029 After reset deasserts, the first write SHALL occur on the first rising edge at which reset=0 and wr_en=1.

Verification
REQ-030 Reset, then read all addresses on A and B -> all 0; assert reset mid-run after writes -> every entry 0 before next edge.
REQ-031 Write 16'hAAAA to addr 3, 16'hBBBB to addr 5 on consecutive edges; read A=3, B=5 -> AAAA/BBBB; wr_en=0 with wr_data=16'hCCCC for 3 cycles -> values unchanged.
REQ-032 BYPASS=1: wr_en=1, wr_addr=2, wr_data=16'hDDDD, rd_addr_a=2 -> rd_data_a=DDDD in same cycle; BYPASS=0 build -> old value (0) until edge, DDDD after.
REQ-033 ZERO_REG=1: write 16'h1234 to addr 0 -> read addr 0 = 0 before and after edge; ZERO_REG=0 build -> reads 1234 after edge.
REQ-034 DEPTH=6: write 16'h5555 to addr 7 -> discarded, read addr 7 = 0, entries 0..5 unchanged.
REQ-035 Write 16'hBEEF to addr 4 with reset asserted on the same edge -> addr 4 reads 0 after reset releases; next write to addr 4 succeeds.
